// File: rtl/seg_pkg.sv
// Shared display-state codes and fixed glyph patterns for the scanned 7-segment display.
package seg_pkg;

  localparam logic [2:0] DST_IDLE    = 3'b000;
  localparam logic [2:0] DST_WAIT    = 3'b001;
  localparam logic [2:0] DST_MEASURE = 3'b010;
  localparam logic [2:0] DST_EARLY   = 3'b011;
  localparam logic [2:0] DST_FINISH  = 3'b110;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_G     = 7'h3D;
  localparam logic [6:0] SEG_O     = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to 7-segment glyph; non-decimal nibbles render as a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0: seg_o = 7'h3F;
      4'd1: seg_o = 7'h06;
      4'd2: seg_o = 7'h5B;
      4'd3: seg_o = 7'h4F;
      4'd4: seg_o = 7'h66;
      4'd5: seg_o = 7'h6D;
      4'd6: seg_o = 7'h7D;
      4'd7: seg_o = 7'h07;
      4'd8: seg_o = 7'h7F;
      4'd9: seg_o = 7'h6F;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-cathode display driver: per-frame input snapshot, anti-ghost blanking
// at the end of each digit slot, and state-dependent glyph rendering.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned SCAN_DIV    = 4096,
  parameter int unsigned BLANK       = 256,
  parameter int unsigned DP_POS      = 3,
  parameter int unsigned ANIM_FRAMES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_dst,
  input  logic [4*DIGITS-1:0]   i_measured,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_dig
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  localparam logic [PW-1:0] PcntMax  = PW'(SCAN_DIV - 1);
  localparam logic [PW:0]   DriveEnd = (PW+1)'(SCAN_DIV - BLANK);
  localparam logic [IW-1:0] IdxMax   = IW'(DIGITS - 1);
  localparam logic [IW-1:0] DpPos    = IW'(DP_POS);
  localparam logic [FW-1:0] FcntMax  = FW'(ANIM_FRAMES - 1);

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [2:0]             snap_dst_q, snap_dst_d;
  logic [4*DIGITS-1:0]    snap_meas_q, snap_meas_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [IW-1:0]          pos_q, pos_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      dig_q, dig_d;

  logic                   snap_en;
  logic [3:0]             nib;
  logic                   lz_sel;
  logic                   all_zero;
  logic [6:0]             num_seg;
  logic [6:0]             glyph;
  logic                   glyph_dp;

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (pcnt_q == PcntMax) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  assign snap_en = (pcnt_q == '0) && (idx_q == '0);

  // Spinner advances on the previously held snapshot so a fresh IDLE entry shows digit 0
  // for a full ANIM_FRAMES frames.
  always_comb begin
    snap_dst_d  = snap_dst_q;
    snap_meas_d = snap_meas_q;
    fcnt_d      = fcnt_q;
    pos_d       = pos_q;
    if (snap_en) begin
      snap_dst_d  = i_dst;
      snap_meas_d = i_measured;
      if (snap_dst_q == DST_IDLE) begin
        if (fcnt_q == FcntMax) begin
          fcnt_d = '0;
          pos_d  = (pos_q == IdxMax) ? '0 : pos_q + 1'b1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end else begin
        fcnt_d = '0;
        pos_d  = '0;
      end
    end
  end

  // Select the current nibble and whether all nibbles from it upward are zero.
  always_comb begin
    nib      = 4'h0;
    lz_sel   = 1'b0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero && (snap_meas_d[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib    = snap_meas_d[4*i +: 4];
        lz_sel = all_zero;
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble_i (nib),
    .seg_o    (num_seg)
  );

  always_comb begin
    glyph    = SEG_BLANK;
    glyph_dp = 1'b0;
    case (snap_dst_d)
      DST_IDLE:    glyph = (idx_q == pos_d) ? SEG_DASH : SEG_BLANK;
      DST_WAIT:    glyph = SEG_DASH;
      DST_MEASURE: begin
        if (idx_q == IW'(1))      glyph = SEG_G;
        else if (idx_q == IW'(0)) glyph = SEG_O;
      end
      DST_EARLY: begin
        if (idx_q == IW'(2))     glyph = SEG_E;
        else if (idx_q < IW'(2)) glyph = SEG_R;
      end
      DST_FINISH: begin
        glyph    = ((idx_q > DpPos) && lz_sel) ? SEG_BLANK : num_seg;
        glyph_dp = (idx_q == DpPos);
      end
      default: glyph = SEG_BLANK;
    endcase
  end

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    dig_d = '0;
    if ({1'b0, pcnt_q} < DriveEnd) begin
      seg_d = glyph;
      dp_d  = glyph_dp;
      dig_d = DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      snap_dst_q  <= DST_IDLE;
      snap_meas_q <= '1;
      fcnt_q      <= '0;
      pos_q       <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      dig_q       <= '0;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      snap_dst_q  <= snap_dst_d;
      snap_meas_q <= snap_meas_d;
      fcnt_q      <= fcnt_d;
      pos_q       <= pos_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
    end
  end

  assign o_seg = seg_q;
  assign o_dp  = dp_q;
  assign o_dig = dig_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed scenarios plus randomized frames, checked every cycle
// against a frame-level reference model.
module tb_seg_scan_display;

  localparam int DIGITS      = 6;
  localparam int SCAN_DIV    = 8;
  localparam int BLANK       = 2;
  localparam int DP_POS      = 3;
  localparam int ANIM_FRAMES = 2;
  localparam int FRAME       = DIGITS * SCAN_DIV;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [2:0]            dst_r = 3'b001;
  logic [4*DIGITS-1:0]   meas_r = '0;
  logic [6:0]            o_seg;
  logic                  o_dp;
  logic [DIGITS-1:0]     o_dig;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int                  n_edge;
  logic [2:0]          m_dst;
  logic [4*DIGITS-1:0] m_meas;
  int                  run;
  logic [6:0]          exp_seg;
  logic                exp_dp;
  logic [DIGITS-1:0]   exp_dig;

  always #5 clk = ~clk;

  seg_scan_display #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK       (BLANK),
    .DP_POS      (DP_POS),
    .ANIM_FRAMES (ANIM_FRAMES)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_dst      (dst_r),
    .i_measured (meas_r),
    .o_seg      (o_seg),
    .o_dp       (o_dp),
    .o_dig      (o_dig)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] digit_glyph(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] model_glyph(input int d);
    int nibv;
    nibv = int'((m_meas >> (4*d)) & 24'hF);
    case (m_dst)
      3'b000: return (d == (run / ANIM_FRAMES) % DIGITS) ? 7'h40 : 7'h00;
      3'b001: return 7'h40;
      3'b010: return (d == 1) ? 7'h3D : (d == 0) ? 7'h3F : 7'h00;
      3'b011: return (d == 2) ? 7'h79 : (d < 2) ? 7'h50 : 7'h00;
      3'b110: begin
        if (d > DP_POS && (m_meas >> (4*d)) == 0) return 7'h00;
        return digit_glyph(nibv);
      end
      default: return 7'h00;
    endcase
  endfunction

  task automatic model_reset();
    n_edge = 0;
    m_dst  = 3'b000;
    m_meas = '1;
    run    = 0;
  endtask

  // Expected outputs after one clock edge, from the slot position that edge sees.
  task automatic model_edge();
    int pc, ix;
    pc = n_edge % SCAN_DIV;
    ix = (n_edge / SCAN_DIV) % DIGITS;
    if (n_edge % FRAME == 0) begin
      if (m_dst == 3'b000) run++;
      else run = 0;
      m_dst  = dst_r;
      m_meas = meas_r;
    end
    if (pc < SCAN_DIV - BLANK) begin
      exp_dig = DIGITS'(1) << ix;
      exp_seg = model_glyph(ix);
      exp_dp  = (m_dst == 3'b110) && (ix == DP_POS);
    end else begin
      exp_dig = '0;
      exp_seg = '0;
      exp_dp  = 1'b0;
    end
    n_edge++;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("dig", 32'(o_dig), 32'(exp_dig));
      check("seg", 32'(o_seg), 32'(exp_seg));
      check("dp", 32'(o_dp), 32'(exp_dp));
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_dig"}, 32'(o_dig), 32'h0);
    check({tag, "_seg"}, 32'(o_seg), 32'h0);
    check({tag, "_dp"}, 32'(o_dp), 32'h0);
  endtask

  function automatic logic [4*DIGITS-1:0] rand_meas();
    logic [4*DIGITS-1:0] v;
    int lead, r;
    v = '0;
    lead = $urandom_range(0, DIGITS);
    for (int d = 0; d < DIGITS; d++) begin
      if (d < DIGITS - lead) begin
        r = $urandom_range(0, 15);
        v[4*d +: 4] = (r < 12) ? 4'(r % 10) : 4'(r);
      end
    end
    return v;
  endfunction

  function automatic logic [2:0] rand_dst();
    logic [2:0] codes [8];
    codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
    return codes[$urandom_range(0, 7)];
  endfunction

  initial begin
    int k;
    logic [4*DIGITS-1:0] fin_vals [5];
    fin_vals = '{24'h000245, 24'hFFFFFF, 24'h000000, 24'h100000, 24'h0A0000};

    model_reset();
    #1 rst = 1'b1;
    #2 check_blank("reset");
    repeat (2) @(negedge clk);
    check_blank("reset_hold");
    rst = 1'b0;

    // Slot timing with WAIT dashes
    dst_r = 3'b001;
    run_cycles(2 * FRAME);

    // FINISH values, then EARLY and MEASURE glyphs
    dst_r = 3'b110;
    foreach (fin_vals[i]) begin
      meas_r = fin_vals[i];
      run_cycles(2 * FRAME);
    end
    dst_r = 3'b011;
    run_cycles(2 * FRAME);
    dst_r = 3'b010;
    run_cycles(2 * FRAME);

    // Snapshot isolation: change the value while digit 2 is about to be scanned
    dst_r  = 3'b110;
    meas_r = 24'h000245;
    run_cycles(FRAME + 2 * SCAN_DIV);
    meas_r = 24'h999999;
    run_cycles(4 * SCAN_DIV + FRAME);

    // Spinner over a full wrap, then restart after a WAIT frame
    dst_r = 3'b001;
    run_cycles(FRAME);
    dst_r = 3'b000;
    run_cycles(14 * FRAME);
    dst_r = 3'b001;
    run_cycles(FRAME);
    dst_r = 3'b000;
    run_cycles(3 * FRAME);

    // Async reset in the middle of a drive phase
    dst_r = 3'b110;
    meas_r = 24'h123456;
    run_cycles(FRAME + 3);
    #2 rst = 1'b1;
    #1 check_blank("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    dst_r = 3'b001;
    run_cycles(2 * FRAME);

    // Randomized frames with occasional mid-frame input changes
    for (int f = 0; f < 40; f++) begin
      dst_r  = rand_dst();
      meas_r = rand_meas();
      k = $urandom_range(1, FRAME - 1);
      run_cycles(k);
      if ($urandom_range(0, 1) == 1) begin
        dst_r  = rand_dst();
        meas_r = rand_meas();
      end
      run_cycles(FRAME - k);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
